// File: rtl/cnn_fixed_pkg.sv
// cnn_fixed_pkg
// Shared Q1.7 fixed-point definitions for the CNN post-accumulation stages
// (conv2d_1/2/3): format constants, the activation type, the round-half-up
// constant and the signed saturation helper used by requant_sat.
package cnn_fixed_pkg;

  localparam int FRAC_BITS = 7;
  localparam int Q_MAX     = 127;
  localparam int Q_MIN     = -128;
  // Half an output LSB, in accumulator units, for round-half-up.
  localparam int ROUND_K   = 1 << (FRAC_BITS - 1);
  // Width of the intermediate handed to sat_q17; callers sign-extend into it.
  localparam int WIDE_W    = 32;

  typedef logic signed [7:0] q17_t;

  function automatic q17_t sat_q17(input logic signed [WIDE_W-1:0] x);
    if (x > Q_MAX)      return q17_t'(Q_MAX);
    else if (x < Q_MIN) return q17_t'(Q_MIN);
    else                return x[7:0];
  endfunction

endpackage

// File: rtl/requant_sat.sv
// requant_sat
// Combinational requantisation of one accumulator to a Q1.7 activation:
// add the Q1.7 bias aligned to the accumulator's 2*FRAC fractional bits,
// round half up, shift back to FRAC fractional bits, optional ReLU, then
// saturate to [-128, 127].
// Build option: define CONV2_RELU_EN to clamp negative results to zero;
// without it the stage is linear (signed saturation only).
// Ports:
//   acc   in  ACC_W  signed accumulator (2*FRAC fractional bits)
//   bias  in  8      signed Q1.7 bias
//   q     out 8      signed Q1.7 activation
module requant_sat
  import cnn_fixed_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int FRAC  = FRAC_BITS
) (
  input  logic signed [ACC_W-1:0] acc,
  input  q17_t                    bias,
  output q17_t                    q
);

  // Two guard bits keep the bias add and rounding add from overflowing.
  localparam int W = ACC_W + 2;
  localparam logic signed [W-1:0] RND =
    (FRAC == FRAC_BITS) ? W'(ROUND_K) : (W'(1) <<< (FRAC - 1));

  logic signed [W-1:0]      acc_x;
  logic signed [W-1:0]      bias_x;
  logic signed [W-1:0]      sum;
  logic signed [W-1:0]      r;
  logic signed [WIDE_W-1:0] r_w;

  always_comb begin
    acc_x  = {{2{acc[ACC_W-1]}}, acc};
    bias_x = {{(W-8){bias[7]}}, bias};
    sum    = acc_x + (bias_x <<< FRAC);
    r      = (sum + RND) >>> FRAC;
    r_w    = {{(WIDE_W-W){r[W-1]}}, r};
`ifdef CONV2_RELU_EN
    if (r_w < 0) r_w = '0;
`endif
    q      = sat_q17(r_w);
  end

endmodule

// File: rtl/conv2_bias_requant.sv
// conv2_bias_requant
// Post-accumulation stage of conv2d_2. Accepts one raw MAC accumulator per
// output channel (channel-interleaved, ch0..NUM_CH-1 per pixel), fetches the
// channel's Q1.7 bias from the bias ROM, requantises to Q1.7 and streams the
// activation out under valid/ready. Two-stage pipeline, 1 result/cycle.
// Build option: CONV2_RELU_EN enables ReLU (see requant_sat); handshake and
// latency are identical with or without it.
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid/in_ready     accumulator handshake
//   in_acc                signed accumulator, ACC_W bits
//   bias_row/bias_col     bias ROM address (row = channel, column = 0)
//   bias_data             signed Q1.7 bias, combinational ROM read
//   out_valid/out_ready   activation handshake
//   out_data/out_ch       signed Q1.7 activation and its channel index
//   frame_done            high during the last output handshake of a frame
module conv2_bias_requant
  import cnn_fixed_pkg::*;
#(
  parameter int ACC_W   = 24,
  parameter int NUM_CH  = 32,
  parameter int NUM_PIX = 256,
  parameter int FRAC    = FRAC_BITS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [ACC_W-1:0]   in_acc,
  output logic [15:0]               bias_row,
  output logic [15:0]               bias_col,
  input  logic signed [7:0]         bias_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [7:0]         out_data,
  output logic [$clog2(NUM_CH)-1:0] out_ch,
  output logic                      frame_done
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int PIX_W = $clog2(NUM_PIX);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(NUM_PIX - 1);

  logic [CH_W-1:0]         in_ch_cnt;
  logic [CH_W-1:0]         out_ch_cnt;
  logic [PIX_W-1:0]        pix_cnt;

  logic                    vld_p1;
  logic signed [ACC_W-1:0] acc_p1;
  q17_t                    bias_p1;
  logic [CH_W-1:0]         ch_p1;
  q17_t                    q_p1;

  logic accept;
  logic adv;
  logic out_hs;

  assign in_ready = !vld_p1 || !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign adv      = vld_p1 && (!out_valid || out_ready);
  assign out_hs   = out_valid && out_ready;

  // The channel counter is a register, so the ROM row is stable for the
  // whole cycle in which the accumulator is presented.
  assign bias_row = {{(16-CH_W){1'b0}}, in_ch_cnt};
  assign bias_col = '0;

  assign frame_done = out_hs && (out_ch_cnt == LAST_CH) && (pix_cnt == LAST_PIX);

  // ---- stage 1: capture accumulator, bias and channel ----
  always_ff @(posedge clk) begin
    if (accept) begin
      acc_p1  <= in_acc;
      bias_p1 <= bias_data;
      ch_p1   <= in_ch_cnt;
    end
  end

  // ---- stage 1 -> stage 2: requantise ----
  requant_sat #(
    .ACC_W (ACC_W),
    .FRAC  (FRAC)
  ) u_requant (
    .acc  (acc_p1),
    .bias (bias_p1),
    .q    (q_p1)
  );

  // ---- stage 2: output register, handshake and frame counters ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ch_cnt  <= '0;
      vld_p1     <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_ch     <= '0;
      out_ch_cnt <= '0;
      pix_cnt    <= '0;
    end else begin
      if (accept)
        in_ch_cnt <= (in_ch_cnt == LAST_CH) ? '0 : in_ch_cnt + 1'b1;

      if (accept)   vld_p1 <= 1'b1;
      else if (adv) vld_p1 <= 1'b0;

      if (adv) begin
        out_valid <= 1'b1;
        out_data  <= q_p1;
        out_ch    <= ch_p1;
      end else if (out_hs) begin
        out_valid <= 1'b0;
      end

      if (out_hs) begin
        if (out_ch_cnt == LAST_CH) begin
          out_ch_cnt <= '0;
          pix_cnt    <= (pix_cnt == LAST_PIX) ? '0 : pix_cnt + 1'b1;
        end else begin
          out_ch_cnt <= out_ch_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/conv2_bias_requant.md
Name: conv2_bias_requant

Overview:
- Post-accumulation stage for the conv2d_2 layer, between the conv2d_2 MAC array and pooling/next-layer buffer.
- Accepts one raw MAC accumulator per output channel, channel-interleaved: pixel p delivers ch0..ch31, then pixel p+1.
- Fetches that channel's Q1.7 bias from the conv2d_2 bias ROM, adds it, rounds, applies ReLU, saturates to Q1.7.
- Streams 8-bit activations out under valid/ready.

Parameters:
- ACC_W, 24, accumulator width; signed, 14 fractional bits (Q1.7 × Q1.7 products).
- NUM_CH, 32, output channels; equals the bias ROM depth.
- NUM_PIX, 256, output pixels per frame (16×16 feature map).
- FRAC, 7, fractional bits of bias and output (Q1.7).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  accumulator valid.
- in_ready  out  1  stage can accept.
- in_acc  in  ACC_W  signed accumulator.
- bias_row  out  16  bias ROM row address = current input channel count.
- bias_col  out  16  bias ROM column, tied to 0.
- bias_data  in  8  signed Q1.7 bias from ROM (combinational read).
- out_valid  out  1  activation valid.
- out_ready  in  1  downstream can accept.
- out_data  out  8  signed Q1.7 activation.
- out_ch  out  $clog2(NUM_CH)  channel index of out_data.
- frame_done  out  1  one-cycle pulse with the last output handshake of a frame.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_data=0, out_ch=0, frame_done=0, internal s1_valid=0, in_ch_cnt=0, out_ch_cnt=0, pix_cnt=0. in_ready reads 1 one cycle after release. Reset mid-frame discards in-flight data; counters restart at ch0/pixel 0.
- Two-stage pipeline; each stage advances when its successor is empty or being drained.
  - in_ready = !s1_valid || !out_valid || out_ready.
  - Full throughput: 1 accept/cycle with out_ready held high.
  - Accept at edge N → out_valid asserted after edge N+1 (latency 2 edges).
- Stage 1, on in_valid && in_ready:
  - Capture in_acc, and bias_data addressed by bias_row = in_ch_cnt.
  - Increment in_ch_cnt, wrapping NUM_CH-1 → 0.
  - bias_row is a registered counter, so the ROM output is stable in the same cycle.
- Stage 2 arithmetic, width ACC_W+2:
  - sum = acc + (sext(bias) <<< FRAC).
  - r = (sum + 2^(FRAC-1)) >>> FRAC (round half up, arithmetic shift).
  - ReLU: r<0 → 0.
  - Saturate to [-128, 127]; after ReLU the effective range is [0, 127].
  - out_ch = channel captured with the data.
- out_valid stays high and out_data/out_ch stay stable until out_ready.
- Simultaneous output drain and stage-1 advance in the same cycle is lossless.
- Output-side counting:
  - out_ch_cnt wraps at NUM_CH-1; pix_cnt increments on each wrap.
  - frame_done = 1 for exactly the cycle of the handshake on ch NUM_CH-1 of pixel NUM_PIX-1; pix_cnt then wraps to 0.
- No frame gaps needed; back-to-back frames continue seamlessly.

Optional Feature:
- Macro CONV2_RELU_EN.
- Defined: ReLU applied as above.
- Undefined: ReLU removed; output is signed-saturated r in [-128, 127] (linear layer for ablation runs).
- Latency and handshake are identical either way.

Decomposition:
- Shared package cnn_fixed_pkg:
  - Q1.7 constants: FRAC_BITS=7, Q_MAX=127, Q_MIN=-128.
  - Rounding constant.
  - Typedef q17_t (signed [7:0]).
  - Function sat_q17(wide) → q17_t.
- One natural sub-module: requant_sat (combinational add/round/ReLU/saturate), reusable by the conv2d_1/conv2d_3 stages.
- Counters and handshake stay in the top.

Test Plan:
- acc=1000 on ch0 (bias 31) → out_data=39, out_ch=0, out_valid two edges after accept.
- acc=0 on ch8 (bias -32) → 0 with CONV2_RELU_EN; -32 without.
- acc=100000 on ch5 (bias 60) → 127; acc=-100000 on ch16 (bias -55), no macro → -128.
- Stream 32×256 accs with out_ready=1 → 8192 outputs, no bubbles, out_ch cycles 0..31, single frame_done on the 8192nd handshake.
- out_ready toggled randomly (50%) → no loss or duplication, out_data stable while stalled, in_ready drops only when both stages are full.
- rst_n pulsed low mid-pixel (ch 13) → outputs clear immediately; next accept uses bias_row=0.
